// File: rtl/output_queue.sv
// Output word queue with a 4-phase ready/acknowledge pin handshake and a synchronised acknowledge input.
// Optional macro OUTPUT_QUEUE_ZERO_MASK_EN: zero data_out whenever output_byte_is_ready is low.
module output_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       iface_busy,
    input  logic                       output_acknowledge,
    output logic [DATA_W-1:0]          data_out,
    output logic                       output_byte_is_ready,
    output logic                       input_acknowledged,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {O_EMPTY, O_READY, O_WAIT_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               obr_q, obr_d;
    logic               overflow_q, overflow_d;
    logic               in_ack_q;
    logic               ack_meta_q, ack_s_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               wr_en, pop;

    assign wr_ready             = (count_q != FULL);
    assign count                = count_q;
    assign data_out             = data_out_q;
    assign output_byte_is_ready = obr_q;
    assign input_acknowledged   = in_ack_q;
    assign overflow             = overflow_q;

    always_comb begin
        wr_en      = wr_valid && wr_ready;
        pop        = (state_q == O_READY) && ack_s_q;
        state_d    = state_q;
        data_out_d = data_out_q;
        obr_d      = obr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        overflow_d = overflow_q | (wr_valid && !wr_ready);
        case (state_q)
            O_EMPTY: begin
                // Any ack still high here is ignored; it only acts once a word is shown.
                if (count_q != '0) begin
                    state_d    = O_READY;
                    obr_d      = 1'b1;
                    data_out_d = mem_q[rd_ptr_q];
                end
            end
            O_READY: begin
                if (ack_s_q) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = O_WAIT_RELEASE;
                    obr_d    = 1'b0;
                end else begin
                    data_out_d = mem_q[rd_ptr_q];
                end
            end
            O_WAIT_RELEASE: begin
                if (!ack_s_q) begin
                    if (count_q != '0) begin
                        state_d    = O_READY;
                        obr_d      = 1'b1;
                        data_out_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = O_EMPTY;
                    end
                end
            end
            default: begin
                state_d = O_EMPTY;
                obr_d   = 1'b0;
            end
        endcase
`ifdef OUTPUT_QUEUE_ZERO_MASK_EN
        if (!obr_d) data_out_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= O_EMPTY;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            data_out_q <= '0;
            obr_q      <= 1'b0;
            overflow_q <= 1'b0;
            in_ack_q   <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            data_out_q <= data_out_d;
            obr_q      <= obr_d;
            overflow_q <= overflow_d;
            in_ack_q   <= iface_busy;
            ack_meta_q <= output_acknowledge;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
